// File: rtl/keypad_pkg.sv
// Shared types for the keypad event controller: key-code width and type,
// plus the press-tracking FSM state encoding.
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef logic [KEY_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } key_state_t;

endpackage

// File: rtl/key_fifo.sv
// Small power-of-two event FIFO with a combinational head output that reads
// zero while empty; a full FIFO still accepts a push if a pop happens that cycle.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Debounces raw keypad scanner samples into one event per press and queues
// the key codes for a consumer, flagging events dropped on a full queue.
module key_event_ctrl
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  key_code_t              key_code,
  output logic                   ev_valid,
  output key_code_t              ev_code,
  input  logic                   ev_ready,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  key_state_t state;
  key_code_t  cap_code;
  logic [7:0] cnt;
  logic       match;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop;

  assign match    = key_valid && (key_code == cap_code);
  assign push     = (state == DEBOUNCE) && match && (cnt == DEB_LAST);
  assign pop      = ev_ready && !empty;
  assign drop     = push && full && !pop;
  assign ev_valid = !empty;

  // The last matching debounce sample pushes on the same edge it moves to HELD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            cap_code <= key_code;
            cnt      <= '0;
            state    <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state <= HELD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HELD: begin
          if (!key_valid) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (key_valid) begin
            state <= HELD;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cap_code),
    .dout  (ev_code),
    .full  (full),
    .empty (empty),
    .count (ev_count)
  );

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl: expected codes are queued as presses
// are driven and compared as the consumer pops events.
module tb_key_event_ctrl;
  import keypad_pkg::*;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_ready;
  logic [2:0] ev_count;
  logic       overflow;
  logic       ovf_clr;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];

  key_event_ctrl #(
    .DEB_CYCLES (DEB),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_ready  (ev_ready),
    .ev_count  (ev_count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected summary before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    key_valid = 1'b1;
    key_code  = code;
    step(hold);
    key_valid = 1'b0;
    step(rel);
  endtask

  // Pop every queued event and compare it with the scoreboard head.
  task automatic drain(input string name);
    logic [3:0] exp;
    ev_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (!ev_valid) break;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL %s_extra: got code %h, expected no event", name, ev_code);
      end else begin
        exp = exp_q.pop_front();
        if (ev_code !== exp) begin
          n_bad++;
          $display("[TB] FAIL %s_code: got %h, expected %h", name, ev_code, exp);
        end
      end
      step();
    end
    ev_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || ev_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL %s_left: got %0d pending, ev_valid %b, expected 0 pending, ev_valid 0",
               name, exp_q.size(), ev_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; ev_ready = 1'b0; ovf_clr = 1'b0;
    step(2);
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid: got %b expected 0", ev_valid); end
    n_cmp++; if (ev_code !== 4'h0) begin n_bad++; $display("[TB] FAIL rst_code: got %h expected 0", ev_code); end
    n_cmp++; if (ev_count !== 3'd0) begin n_bad++; $display("[TB] FAIL rst_count: got %0d expected 0", ev_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_ovf: got %b expected 0", overflow); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("[TB] FAIL rst_state: got %0d expected %0d", dut.state, IDLE); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_press();
    key_valid = 1'b1; key_code = 4'h7;
    exp_q.push_back(4'h7);
    step();
    for (int k = 1; k <= DEB; k++) begin
      step();
      if (k < DEB) begin
        n_cmp++;
        if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL single_early_%0d: got %b expected 0", k, ev_valid); end
      end
    end
    n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL single_valid: got %b expected 1", ev_valid); end
    n_cmp++; if (ev_code !== 4'h7) begin n_bad++; $display("[TB] FAIL single_code: got %h expected 7", ev_code); end
    step(5);
    key_valid = 1'b0;
    step(6);
    n_cmp++; if (ev_count !== 3'd1) begin n_bad++; $display("[TB] FAIL single_count: got %0d expected 1", ev_count); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("[TB] FAIL single_state: got %0d expected %0d", dut.state, IDLE); end
    drain("single");
  endtask

  task automatic test_bounce();
    key_valid = 1'b1; key_code = 4'hA;
    step(3);
    key_valid = 1'b0;
    step();
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("[TB] FAIL bounce_state: got %0d expected %0d", dut.state, IDLE); end
    n_cmp++; if (ev_count !== 3'd0) begin n_bad++; $display("[TB] FAIL bounce_count: got %0d expected 0", ev_count); end
    step(4);
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL bounce_valid: got %b expected 0", ev_valid); end
  endtask

  task automatic test_release_glitch();
    key_valid = 1'b1; key_code = 4'h3;
    exp_q.push_back(4'h3);
    step(6);
    key_code = 4'h9;
    step(2);
    key_valid = 1'b0;
    step();
    n_cmp++; if (dut.state !== RELEASE) begin n_bad++; $display("[TB] FAIL glitch_rel: got %0d expected %0d", dut.state, RELEASE); end
    key_valid = 1'b1;
    step();
    n_cmp++; if (dut.state !== HELD) begin n_bad++; $display("[TB] FAIL glitch_held: got %0d expected %0d", dut.state, HELD); end
    key_valid = 1'b0;
    step(6);
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("[TB] FAIL glitch_idle: got %0d expected %0d", dut.state, IDLE); end
    n_cmp++; if (ev_count !== 3'd1) begin n_bad++; $display("[TB] FAIL glitch_count: got %0d expected 1", ev_count); end
    drain("glitch");
  endtask

  task automatic test_overflow();
    for (int c = 1; c <= 5; c++) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(4'(c));
      press(4'(c), 6, 6);
    end
    n_cmp++; if (ev_count !== 3'd4) begin n_bad++; $display("[TB] FAIL ovf_count: got %0d expected 4", ev_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_clr: got %b expected 0", overflow); end
    drain("ovf");
  endtask

  task automatic test_full_push_pop();
    for (int c = 1; c <= 4; c++) begin
      exp_q.push_back(4'(c));
      press(4'(c), 6, 6);
    end
    n_cmp++; if (ev_count !== 3'd4) begin n_bad++; $display("[TB] FAIL fpp_fill: got %0d expected 4", ev_count); end
    key_valid = 1'b1; key_code = 4'h6;
    exp_q.push_back(4'h6);
    step(4);
    ev_ready = 1'b1;
    n_cmp++; if (ev_code !== exp_q[0]) begin n_bad++; $display("[TB] FAIL fpp_head: got %h expected %h", ev_code, exp_q[0]); end
    void'(exp_q.pop_front());
    step();
    ev_ready = 1'b0;
    n_cmp++; if (ev_count !== 3'd4) begin n_bad++; $display("[TB] FAIL fpp_count: got %0d expected 4", ev_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL fpp_ovf: got %b expected 0", overflow); end
    step();
    key_valid = 1'b0;
    step(6);
    drain("fpp");
  endtask

  task automatic test_ready_empty();
    ev_ready = 1'b1;
    step(3);
    ev_ready = 1'b0;
    n_cmp++; if (ev_count !== 3'd0) begin n_bad++; $display("[TB] FAIL rdy_count: got %0d expected 0", ev_count); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rdy_valid: got %b expected 0", ev_valid); end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(4'h8); press(4'h8, 6, 6);
    exp_q.push_back(4'h9); press(4'h9, 6, 6);
    key_valid = 1'b1; key_code = 4'hB;
    step(2);
    rst = 1'b1; ev_ready = 1'b1;
    step();
    exp_q.delete();
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_valid: got %b expected 0", ev_valid); end
    n_cmp++; if (ev_count !== 3'd0) begin n_bad++; $display("[TB] FAIL rmid_count: got %0d expected 0", ev_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_ovf: got %b expected 0", overflow); end
    n_cmp++; if (ev_code !== 4'h0) begin n_bad++; $display("[TB] FAIL rmid_code: got %h expected 0", ev_code); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("[TB] FAIL rmid_state: got %0d expected %0d", dut.state, IDLE); end
    rst = 1'b0; ev_ready = 1'b0;
    exp_q.push_back(4'hB);
    step();
    step(DEB - 1);
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL held_early: got %b expected 0", ev_valid); end
    step();
    n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL held_valid: got %b expected 1", ev_valid); end
    step(2);
    key_valid = 1'b0;
    step(6);
    drain("held");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_release_glitch();
    test_overflow();
    test_full_push_pop();
    test_ready_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
